// File: rtl/preif_if_queue_if.sv
// preif_if_queue_if: pre-IF -> IF PC-buffer queue handshake bundle.
// master: pre-IF/IF side driving entries, flush and consume.
// slave : queue side presenting ready, head entry and fill level.
interface preif_if_queue_if #(
    parameter int unsigned PC_BUF_W = 64,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                excep_flush_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [PC_BUF_W-1:0] inst_pc_buffer_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [PC_BUF_W-1:0] inst_pc_buffer_o;
    logic [CNT_W-1:0]    count_o;

    modport master (
        output excep_flush_i,
        output in_valid_i,
        input  in_ready_o,
        output inst_pc_buffer_i,
        input  out_valid_o,
        output out_ready_i,
        input  inst_pc_buffer_o,
        input  count_o
    );

    modport slave (
        input  excep_flush_i,
        input  in_valid_i,
        output in_ready_o,
        input  inst_pc_buffer_i,
        output out_valid_o,
        input  out_ready_i,
        output inst_pc_buffer_o,
        output count_o
    );
endinterface

// File: rtl/preif_if_queue.sv
// preif_if_queue: DEPTH-entry circular PC-buffer queue between pre-IF and IF.
// Lets pre-IF run ahead while IF stalls; exception flush drops all entries.
// Optional macro PREIF_QUEUE_BYPASS_EN: forward an entry straight through
// when the queue is empty and IF is ready in the same cycle.
module preif_if_queue #(
    parameter int unsigned PC_BUF_W = 64,
    parameter int unsigned DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    preif_if_queue_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_BUF_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                empty;
    logic                full;
    logic                bypass;
    logic                push;
    logic                pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Fill-level flags and input-side ready (independent of out_ready_i).
    assign empty          = (count == '0);
    assign full           = (count == CNT_W'(DEPTH));
    assign bus.in_ready_o = ~full;
    assign bus.count_o    = count;

`ifdef PREIF_QUEUE_BYPASS_EN
    // Empty queue with a ready consumer: hand the input straight to IF.
    assign bypass           = empty & bus.in_valid_i & bus.out_ready_i & ~bus.excep_flush_i;
    assign bus.out_valid_o  = (~empty | bypass) & ~bus.excep_flush_i;
    assign bus.inst_pc_buffer_o = bypass          ? bus.inst_pc_buffer_i :
                                  bus.out_valid_o ? mem[rd_ptr]          : '0;
`else
    // Registered-only path: head entry visible once stored, masked when invalid.
    assign bypass           = 1'b0;
    assign bus.out_valid_o  = ~empty & ~bus.excep_flush_i;
    assign bus.inst_pc_buffer_o = bus.out_valid_o ? mem[rd_ptr] : '0;
`endif

    // Handshake qualification; a bypassed entry is neither stored nor popped.
    assign push = bus.in_valid_i & ~full & ~bus.excep_flush_i & ~bypass;
    assign pop  = bus.out_valid_o & bus.out_ready_i & ~bypass;

    // Pointer and count update; flush wins over push/pop, reset over all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.excep_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.inst_pc_buffer_i;
        end
    end
endmodule

// File: tb/tb_preif_if_queue.sv
// tb_preif_if_queue: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based model of the PC-buffer queue.
module tb_preif_if_queue;
    localparam int unsigned W = 64;
    localparam int unsigned D = 4;
`ifdef PREIF_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    preif_if_queue_if #(.PC_BUF_W(W), .DEPTH(D)) q_if ();

    preif_if_queue #(.PC_BUF_W(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (q_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mq [$];
    logic [W-1:0] got [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        q_if.in_valid_i       = v;
        q_if.inst_pc_buffer_i = d;
        q_if.out_ready_i      = r;
        q_if.excep_flush_i    = f;
    endtask

    // One cycle: new inputs just after the edge, return once they have settled.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #1;
        drive(v, d, r, f);
        #1;
    endtask

    // Per-cycle check against the model, then advance the model by one edge.
    always @(negedge clk) begin : cmp
        int n;
        bit byp;
        bit ev;
        bit er;
        logic [W-1:0] ed;
        if (rst) begin
            chk("rst_count", 64'(q_if.count_o), 64'd0);
            chk("rst_in_ready", 64'(q_if.in_ready_o), 64'd1);
            chk("rst_out_valid", 64'(q_if.out_valid_o), 64'd0);
            chk("rst_data", 64'(q_if.inst_pc_buffer_o), 64'd0);
            mq.delete();
        end else begin
            n   = mq.size();
            er  = (n < D);
            byp = BYP && (n == 0) && q_if.in_valid_i && q_if.out_ready_i && !q_if.excep_flush_i;
            ev  = ((n != 0) || byp) && !q_if.excep_flush_i;
            ed  = !ev ? '0 : (byp ? q_if.inst_pc_buffer_i : mq[0]);
            chk("count", 64'(q_if.count_o), 64'(n));
            chk("in_ready", 64'(q_if.in_ready_o), 64'(er));
            chk("out_valid", 64'(q_if.out_valid_o), 64'(ev));
            chk("data", 64'(q_if.inst_pc_buffer_o), 64'(ed));
            if (q_if.excep_flush_i) begin
                mq.delete();
            end else begin
                if (ev && q_if.out_ready_i) begin
                    got.push_back(ed);
                    if (!byp) void'(mq.pop_front());
                end
                if (q_if.in_valid_i && er && !byp) mq.push_back(q_if.inst_pc_buffer_i);
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("init_count", 64'(q_if.count_o), 64'd0);
        chk("init_ready", 64'(q_if.in_ready_o), 64'd1);
        chk("init_valid", 64'(q_if.out_valid_o), 64'd0);
        chk("init_data", 64'(q_if.inst_pc_buffer_o), 64'd0);
        rst = 1'b0;

        // Fill to DEPTH with IF stalled, try a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h1c000000 + 64'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 64'h1c000010, 1'b0, 1'b0);
        chk("full_count", 64'(q_if.count_o), 64'd4);
        chk("full_ready", 64'(q_if.in_ready_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_valid", 64'(q_if.out_valid_o), 64'd1);
            chk("drain_data", q_if.inst_pc_buffer_o, 64'h1c000000 + 64'(4 * k));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("drained_count", 64'(q_if.count_o), 64'd0);
        chk("drained_valid", 64'(q_if.out_valid_o), 64'd0);

        // Steady push+pop at count 2 across several pointer wraps.
        cyc(1'b1, 64'h1c001000, 1'b0, 1'b0);
        cyc(1'b1, 64'h1c001004, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 64'h1c001008 + 64'(4 * i), 1'b1, 1'b0);
            chk("wrap_count", 64'(q_if.count_o), 64'd2);
            chk("wrap_data", q_if.inst_pc_buffer_o, 64'h1c001000 + 64'(4 * i));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("wrap_end_count", 64'(q_if.count_o), 64'd0);

        // Flush at count 3 with a competing push and a ready consumer.
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h1c000040 + 64'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 64'h1c000100, 1'b1, 1'b1);
        chk("flush_valid", 64'(q_if.out_valid_o), 64'd0);
        chk("flush_data", q_if.inst_pc_buffer_o, 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("post_flush_count", 64'(q_if.count_o), 64'd0);
        chk("post_flush_valid", 64'(q_if.out_valid_o), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        found = 1'b0;
        foreach (got[i]) if (got[i] == 64'h1c000100) found = 1'b1;
        chk("flush_entry_dropped", 64'(found), 64'd0);

        // Full queue popped while pre-IF offers: pop only, no push.
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h1c000300 + 64'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 64'h1c000310, 1'b1, 1'b0);
        chk("fullpop_count", 64'(q_if.count_o), 64'd4);
        chk("fullpop_ready", 64'(q_if.in_ready_o), 64'd0);
        chk("fullpop_data", q_if.inst_pc_buffer_o, 64'h1c000300);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("fullpop_after", 64'(q_if.count_o), 64'd3);
        chk("fullpop_head", q_if.inst_pc_buffer_o, 64'h1c000304);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("fullpop_empty", 64'(q_if.count_o), 64'd0);

        // Empty queue with ready consumer: bypass or one-cycle latency.
        cyc(1'b1, 64'h1c000200, 1'b1, 1'b0);
`ifdef PREIF_QUEUE_BYPASS_EN
        chk("byp_valid", 64'(q_if.out_valid_o), 64'd1);
        chk("byp_data", q_if.inst_pc_buffer_o, 64'h1c000200);
        chk("byp_count", 64'(q_if.count_o), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("byp_next_count", 64'(q_if.count_o), 64'd0);
        chk("byp_next_valid", 64'(q_if.out_valid_o), 64'd0);
`else
        chk("nobyp_valid", 64'(q_if.out_valid_o), 64'd0);
        chk("nobyp_data", q_if.inst_pc_buffer_o, 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("nobyp_next_count", 64'(q_if.count_o), 64'd1);
        chk("nobyp_next_valid", 64'(q_if.out_valid_o), 64'd1);
        chk("nobyp_next_data", q_if.inst_pc_buffer_o, 64'h1c000200);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("nobyp_end_count", 64'(q_if.count_o), 64'd0);
`endif

        // Asynchronous reset mid-operation at count 3, checked before any edge.
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'h1c000400 + 64'(4 * i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(q_if.count_o), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(q_if.count_o), 64'd0);
        chk("arst_valid", 64'(q_if.out_valid_o), 64'd0);
        chk("arst_data", q_if.inst_pc_buffer_o, 64'd0);
        chk("arst_ready", 64'(q_if.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic with phases biased toward filling or draining.
        for (int c = 0; c < 3000; c++) begin
            int ph;
            bit v;
            bit r;
            ph = (c / 150) % 3;
            v  = (ph == 0) ? ($urandom_range(0, 3) != 0) : (ph == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
            r  = (ph == 0) ? ($urandom_range(0, 3) == 0) : (ph == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            drive(v, {$urandom, $urandom}, r, $urandom_range(0, 39) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
